mult_eu_pipe: RTL and testbench

- Parametrised, self-contained pipelined RV32M/RV64M multiply execution unit.
- Replaces the fixed-width IP-based multiplier EU.
- Sits between the multiply reservation station and the CDB arbiter, with a valid/ready handshake on both sides.
- New behaviour:
  - per-stage (bubble-collapsing) stall;
  - speculative branch-mask resolve and squash on every in-flight stage;
  - generic XLEN and depth.

---
 rtl/mult_eu_pipe.sv | 134 +++++++++++++
 tb/tb_mult_eu_pipe.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_eu_pipe.sv
// Pipelined RV32M/RV64M multiply execution unit: valid/ready on both sides,
// per-stage stall with bubble collapse, branch-mask resolve/squash and late flush.
module mult_eu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 16,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [MASK_W-1:0] in_mask,
  input  logic              br_done,
  input  logic              br_mispredict,
  input  logic [MASK_W-1:0] br_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [MASK_W-1:0] out_mask,
  output logic              busy
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] kill;
  logic [MASK_W-1:0] mask  [STAGES];
  logic [MASK_W-1:0] rmask [STAGES];
  logic [TAG_W-1:0]  tag   [STAGES];
  logic [WIDTH-1:0]  res   [1:STAGES-1];

  op_e               op0;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;

  logic              resolve_ok;
  logic              resolve_bad;
  logic              in_kill;
  logic [MASK_W-1:0] in_rmask;
  logic              capture;

  assign resolve_ok  = br_done && !br_mispredict;
  assign resolve_bad = br_done && br_mispredict;
  assign in_kill     = resolve_bad && |(in_mask & br_id);
  assign in_rmask    = resolve_ok ? (in_mask & ~br_id) : in_mask;

  // A stage can take new data when it or any stage ahead of it is empty,
  // or the output is being drained; this is the unrolled rdy[k] chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy[k]   = out_ready || !(&v[STAGES-1:k]);
    assign kill[k]  = resolve_bad && |(mask[k] & br_id);
    assign rmask[k] = resolve_ok ? (mask[k] & ~br_id) : mask[k];
  end

  assign capture = in_valid && rdy[0] && !flush;

  // Low 2*WIDTH bits of the (WIDTH+1)-bit signed product equal the product of
  // the operands extended straight to 2*WIDTH bits, so no wider multiplier is needed.
  logic              a_sign;
  logic              b_sign;
  logic [2*WIDTH-1:0] a_x;
  logic [2*WIDTH-1:0] b_x;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   s0_res;

  assign a_sign = ((op0 == OP_MULH) || (op0 == OP_MULHSU)) && a0[WIDTH-1];
  assign b_sign = (op0 == OP_MULH) && b0[WIDTH-1];
  assign a_x    = {{WIDTH{a_sign}}, a0};
  assign b_x    = {{WIDTH{b_sign}}, b0};
  assign prod   = a_x * b_x;
  assign s0_res = (op0 == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage behind it, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= rdy[0] ? (in_valid && !in_kill) : (v[0] && !kill[0]);
      for (int k = 1; k < STAGES; k++) begin
        v[k] <= rdy[k] ? (v[k-1] && !kill[k-1]) : (v[k] && !kill[k]);
      end
    end
  end

  // NOTE: payload registers carry no reset; their contents are only observed
  // while the matching valid bit is set, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (capture) begin
      op0    <= op_e'(in_op);
      a0     <= in_a;
      b0     <= in_b;
      tag[0] <= in_tag;
    end
    mask[0] <= rdy[0] ? in_rmask : rmask[0];

    if (rdy[1] && v[0]) begin
      res[1] <= s0_res;
      tag[1] <= tag[0];
    end
    mask[1] <= rdy[1] ? rmask[0] : rmask[1];

    for (int k = 2; k < STAGES; k++) begin
      if (rdy[k] && v[k-1]) begin
        res[k] <= res[k-1];
        tag[k] <= tag[k-1];
      end
      mask[k] <= rdy[k] ? rmask[k-1] : rmask[k];
    end
  end

  assign in_ready   = rdy[0];
  assign out_valid  = v[STAGES-1] && !flush && !kill[STAGES-1];
  assign out_result = res[STAGES-1];
  assign out_tag    = tag[STAGES-1];
  assign out_mask   = rmask[STAGES-1];
  assign busy       = |v;

endmodule

// File: tb/tb_mult_eu_pipe.sv
// Self-checking bench for mult_eu_pipe: vector table, random traffic and
// hand sequences for stall, bubble collapse, branch squash, flush and reset.
module tb_mult_eu_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 16;
  localparam int MASK_W = 4;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [15:0] tag;
    logic [3:0]  mask;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [MASK_W-1:0] in_mask;
  logic              br_done;
  logic              br_mispredict;
  logic [MASK_W-1:0] br_id;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [MASK_W-1:0] out_mask;
  logic              busy;

  int          tests  = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] cur_exp;

  mult_eu_pipe #(
    .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .MASK_W(MASK_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_mask(in_mask),
    .br_done(br_done), .br_mispredict(br_mispredict), .br_id(br_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_mask(out_mask), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (op)
      MULH:    p = sa * sbv;
      MULHSU:  p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] tag, input logic [3:0] mask, input logic [31:0] exp);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_mask  = mask;
    cur_exp  = exp;
    in_valid = 1'b1;
  endtask

  // Holds the op until accepted; a stalled pipe is unblocked by raising out_ready.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] tag, input logic [3:0] mask, input logic [31:0] exp);
    bit ok = 1'b0;
    present(op, a, b, tag, mask, exp);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
      out_ready = 1'b1;
    end
    if (!ok) fail("send_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
    tick();
  endtask

  task automatic latency_test(input logic [15:0] tag);
    out_ready = 1'b1;
    send(MUL, 32'd7, 32'hFFFF_FFFD, tag, 4'b0000, 32'hFFFF_FFEB);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_cycle3_valid", out_valid, 1);
    check("lat_result", out_result, 32'hFFFF_FFEB);
    check("lat_tag", out_tag, tag);
    tick();
  endtask

  // Scoreboard: apply flush/resolve to the expected queue, then pop on a
  // transfer, then push the op being accepted this cycle.
  always @(negedge clk) begin
    exp_t        e;
    exp_t        keep[$];
    logic [3:0]  m;
    if (!rst_n) begin
      sb.delete();
    end else if (flush) begin
      check("flush_out_valid", out_valid, 0);
      sb.delete();
    end else begin
      if (br_done) begin
        keep.delete();
        foreach (sb[i]) begin
          e = sb[i];
          if (br_mispredict) begin
            if ((e.mask & br_id) == 4'b0) keep.push_back(e);
          end else begin
            e.mask = e.mask & ~br_id;
            keep.push_back(e);
          end
        end
        sb = keep;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_tag", out_tag, e.tag);
          check("sb_mask", out_mask, e.mask);
        end
      end
      if (in_valid && in_ready) begin
        m = in_mask;
        if (br_done && !br_mispredict) m = m & ~br_id;
        if (!(br_done && br_mispredict && ((in_mask & br_id) != 4'b0))) begin
          e.res  = cur_exp;
          e.tag  = in_tag;
          e.mask = m;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    vec_t        vecs[11];
    int          idx;
    int          acc;
    int          n_out;
    bit          a_now;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[3]  = '{MULHSU, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000};
    vecs[4]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5]  = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000};
    vecs[9]  = '{MULHU,  32'h0001_0000,  32'h0001_0000, 32'h0000_0001};
    vecs[10] = '{MULH,   32'h7FFF_FFFF,  32'h8000_0000, 32'hC000_0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = MUL;
    in_a = '0; in_b = '0; in_tag = '0; in_mask = '0;
    br_done = 1'b0; br_mispredict = 1'b0; br_id = '0;
    out_ready = 1'b1; cur_exp = '0;

    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    latency_test(16'h1234);

    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, 16'(16'h0200 + i), 4'b0000, vecs[i].res);
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      out_ready = ($urandom_range(0, 3) != 0);
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      send(rop, ra, rb, 16'(16'h0800 + i), 4'b0000, model(rop, ra, rb));
    end
    drain();

    // Backpressure: three fill the pipe, then a gap-free drain of five.
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    present(MUL, 32'(idx + 1), 32'd3, 16'(16'h0300 + idx), 4'b0000, 32'((idx + 1) * 3));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_now = in_valid && in_ready;
      tick();
      if (a_now) begin
        acc++;
        idx++;
        if (idx < 5) present(MUL, 32'(idx + 1), 32'd3, 16'(16'h0300 + idx), 4'b0000, 32'((idx + 1) * 3));
        else in_valid = 1'b0;
      end
    end
    check("bp_accepted", acc, 3);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_held_valid", out_valid, 1);
    check("bp_out_held_tag", out_tag, 16'h0300);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_drain_valid_%0d", c), out_valid, 1);
      check($sformatf("bp_drain_tag_%0d", c), out_tag, 16'(16'h0300 + c));
      a_now = in_valid && in_ready;
      tick();
      if (a_now) begin
        idx++;
        if (idx < 5) present(MUL, 32'(idx + 1), 32'd3, 16'(16'h0300 + idx), 4'b0000, 32'((idx + 1) * 3));
        else in_valid = 1'b0;
      end
    end
    drain();

    // Bubble collapse: A stalls at the output, B closes the gap behind it.
    out_ready = 1'b0;
    send(MUL, 32'd5, 32'd6, 16'h0400, 4'b0000, 32'd30);
    tick();
    send(MUL, 32'd9, 32'd9, 16'h0401, 4'b0000, 32'd81);
    tick();
    present(MUL, 32'd2, 32'd3, 16'h0402, 4'b0000, 32'd6);
    @(negedge clk);
    check("bubble_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble_full_in_ready", in_ready, 0);
    check("bubble_head_tag", out_tag, 16'h0400);
    tick();
    drain();

    // Branch masks: squash the middle op, resolve the head op's branch.
    out_ready = 1'b0;
    send(MUL, 32'd11, 32'd2, 16'h0500, 4'b0001, 32'd22);
    send(MUL, 32'd12, 32'd2, 16'h0501, 4'b0010, 32'd24);
    send(MUL, 32'd13, 32'd2, 16'h0502, 4'b0000, 32'd26);
    br_done = 1'b1; br_mispredict = 1'b1; br_id = 4'b0010;
    @(negedge clk);
    check("br_misp_head_valid", out_valid, 1);
    tick();
    br_done = 1'b0; br_mispredict = 1'b0; br_id = '0;
    tick();
    br_done = 1'b1; br_id = 4'b0001; out_ready = 1'b1;
    @(negedge clk);
    check("br_ok_valid", out_valid, 1);
    check("br_ok_tag", out_tag, 16'h0500);
    check("br_ok_mask", out_mask, 4'b0000);
    tick();
    br_done = 1'b0; br_id = '0;
    n_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_out++;
        check("br_survivor_tag", out_tag, 16'h0502);
      end
      tick();
    end
    check("br_transfers", n_out, 1);

    // Mispredict hitting the output stage suppresses out_valid at once.
    out_ready = 1'b0;
    send(MUL, 32'd3, 32'd3, 16'h0510, 4'b0100, 32'd9);
    tick();
    tick();
    @(negedge clk);
    check("misp_out_pre_valid", out_valid, 1);
    tick();
    br_done = 1'b1; br_mispredict = 1'b1; br_id = 4'b0100;
    @(negedge clk);
    check("misp_out_kill", out_valid, 0);
    check("misp_busy_same_cycle", busy, 1);
    tick();
    br_done = 1'b0; br_mispredict = 1'b0; br_id = '0;
    @(negedge clk);
    check("misp_busy_next", busy, 0);
    tick();

    // Flush with three ops in flight.
    out_ready = 1'b0;
    send(MUL, 32'd4, 32'd4, 16'h0600, 4'b0000, 32'd16);
    send(MUL, 32'd5, 32'd5, 16'h0601, 4'b0000, 32'd25);
    send(MUL, 32'd6, 32'd6, 16'h0602, 4'b0000, 32'd36);
    @(negedge clk);
    check("flush_pre_valid", out_valid, 1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_same_cycle", out_valid, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_next", busy, 0);
    check("flush_in_ready_next", in_ready, 1);
    tick();

    // Asynchronous reset mid-operation, between clock edges.
    out_ready = 1'b0;
    send(MUL, 32'd7, 32'd7, 16'h0700, 4'b0000, 32'd49);
    send(MUL, 32'd8, 32'd8, 16'h0701, 4'b0000, 32'd64);
    send(MUL, 32'd9, 32'd7, 16'h0702, 4'b0000, 32'd63);
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    latency_test(16'h0777);

    drain();
    check("sb_empty_at_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
